// File: rtl/branch_resolver.sv
// rtl/branch_resolver.sv - EX-stage branch resolution: predictor update, wrong-path flush, PC redirect, perf counters
module branch_resolver #(
   parameter int ADDR_W = 32,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ex_valid,
   input  logic              ex_branch,
   input  logic              ex_hold,
   input  logic              ex_prdt_br,
   input  logic              ex_taken,
   input  logic [ADDR_W-1:0] ex_target,
   input  logic [ADDR_W-1:0] ex_pc_plus4,
   input  logic              redirect_ready,
   output logic              Branch,
   output logic              prdt_work,
   output logic              cancel,
   output logic              flush,
   output logic              redirect_valid,
   output logic [ADDR_W-1:0] redirect_pc,
   output logic              res_busy,
   output logic [CNT_W-1:0]  br_cnt,
   output logic [CNT_W-1:0]  mis_cnt
);

   typedef enum logic [1:0] {
      IDLE  = 2'b01,
      REDIR = 2'b10
   } state_t;

   state_t              state_q, state_d;
   logic                upd_q, upd_d;
   logic                cancel_q, cancel_d;
   logic                redirect_valid_q, redirect_valid_d;
   logic [ADDR_W-1:0]   redirect_pc_q, redirect_pc_d;
   logic [CNT_W-1:0]    br_cnt_q, br_cnt_d;
   logic [CNT_W-1:0]    mis_cnt_q, mis_cnt_d;

   logic                resolve;
   logic                mispred;
   logic [ADDR_W-1:0]   fix_pc;

   assign resolve = ex_valid & ex_branch & ~ex_hold & (state_q == IDLE);
   assign mispred = resolve & (ex_prdt_br != ex_taken);
   assign fix_pc  = ex_taken ? ex_target : ex_pc_plus4;

   always_comb begin
      state_d          = state_q;
      redirect_valid_d = redirect_valid_q;
      redirect_pc_d    = redirect_pc_q;
      upd_d            = resolve;
      cancel_d         = resolve & ~ex_taken;
      br_cnt_d         = br_cnt_q;
      mis_cnt_d        = mis_cnt_q;

      case (state_q)
         IDLE: begin
            if (mispred) begin
               state_d          = REDIR;
               redirect_valid_d = 1'b1;
               redirect_pc_d    = fix_pc;
            end
         end
         REDIR: begin
            if (redirect_valid_q && redirect_ready) begin
               state_d          = IDLE;
               redirect_valid_d = 1'b0;
            end
         end
         default: begin
            state_d          = IDLE;
            redirect_valid_d = 1'b0;
         end
      endcase

      // Saturating counters: pin at all-ones rather than wrap
      if (resolve && (br_cnt_q != {CNT_W{1'b1}}))
         br_cnt_d = br_cnt_q + CNT_W'(1);
      if (mispred && (mis_cnt_q != {CNT_W{1'b1}}))
         mis_cnt_d = mis_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q          <= IDLE;
         upd_q            <= 1'b0;
         cancel_q         <= 1'b0;
         redirect_valid_q <= 1'b0;
         redirect_pc_q    <= '0;
         br_cnt_q         <= '0;
         mis_cnt_q        <= '0;
      end else begin
         state_q          <= state_d;
         upd_q            <= upd_d;
         cancel_q         <= cancel_d;
         redirect_valid_q <= redirect_valid_d;
         redirect_pc_q    <= redirect_pc_d;
         br_cnt_q         <= br_cnt_d;
         mis_cnt_q        <= mis_cnt_d;
      end
   end

   assign Branch         = upd_q;
   assign prdt_work      = upd_q;
   assign cancel         = cancel_q;
   assign redirect_valid = redirect_valid_q;
   assign redirect_pc    = redirect_pc_q;
   assign br_cnt         = br_cnt_q;
   assign mis_cnt        = mis_cnt_q;
   // mispred is combinational off EX inputs, so gate it while reset is held
   assign flush          = rst & (mispred | (state_q == REDIR));
   assign res_busy       = (state_q == REDIR);

endmodule

// File: tb/tb_branch_resolver.sv
// tb/tb_branch_resolver.sv - scoreboard bench for branch_resolver
module tb_branch_resolver;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        ex_valid = 1'b0, ex_branch = 1'b0, ex_hold = 1'b0;
   logic        ex_prdt_br = 1'b0, ex_taken = 1'b0;
   logic [31:0] ex_target = '0, ex_pc_plus4 = '0;
   logic        redirect_ready = 1'b0;
   logic        Branch, prdt_work, cancel, flush, redirect_valid, res_busy;
   logic [31:0] redirect_pc;
   logic [3:0]  br_cnt, mis_cnt;

   int checks = 0;
   int failures = 0;

   logic        upd_exp[$];
   logic [31:0] redir_exp[$];

   branch_resolver #(.ADDR_W(32), .CNT_W(4)) dut (
      .clk(clk), .rst(rst),
      .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_hold(ex_hold),
      .ex_prdt_br(ex_prdt_br), .ex_taken(ex_taken),
      .ex_target(ex_target), .ex_pc_plus4(ex_pc_plus4),
      .redirect_ready(redirect_ready),
      .Branch(Branch), .prdt_work(prdt_work), .cancel(cancel), .flush(flush),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .res_busy(res_busy), .br_cnt(br_cnt), .mis_cnt(mis_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: pop expected update / redirect whenever the DUT presents one
   always @(negedge clk) begin
      if (rst) begin
         if (prdt_work) begin
            if (upd_exp.size() == 0) begin
               chk("unexpected_prdt_work", 32'(prdt_work), 32'd0);
            end else begin
               chk("upd_cancel", 32'(cancel), 32'(upd_exp.pop_front()));
               chk("upd_branch", 32'(Branch), 32'd1);
            end
         end else if (Branch || cancel) begin
            chk("upd_without_strobe", 32'({Branch, cancel}), 32'd0);
         end
         if (redirect_valid && redirect_ready) begin
            if (redir_exp.size() == 0)
               chk("unexpected_redirect", 32'(redirect_valid), 32'd0);
            else
               chk("redirect_pc", redirect_pc, redir_exp.pop_front());
         end
      end
   end

   task automatic idle_in();
      ex_valid = 1'b0; ex_branch = 1'b0; ex_hold = 1'b0;
      ex_prdt_br = 1'b0; ex_taken = 1'b0;
   endtask

   task automatic next_cycle();
      @(posedge clk); #1;
   endtask

   // Apply one EX vector for one cycle with hand-computed expectations
   task automatic drive(input logic h, input logic p, input logic t,
                        input logic [31:0] tgt, input logic [31:0] pc4,
                        input logic exp_res, input logic exp_mis,
                        input logic [31:0] exp_pc, input logic exp_flush);
      ex_valid = 1'b1; ex_branch = 1'b1; ex_hold = h;
      ex_prdt_br = p; ex_taken = t; ex_target = tgt; ex_pc_plus4 = pc4;
      if (exp_res) upd_exp.push_back(~t);
      if (exp_mis) redir_exp.push_back(exp_pc);
      @(negedge clk);
      chk("flush", 32'(flush), 32'(exp_flush));
      next_cycle();
      idle_in();
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_outs"}, 32'({Branch, prdt_work, cancel, flush, redirect_valid, res_busy}), 32'd0);
      chk({tag, "_pc"}, redirect_pc, 32'd0);
      chk({tag, "_cnt"}, 32'({br_cnt, mis_cnt}), 32'd0);
   endtask

   initial begin
      // Reset state
      rst = 1'b0;
      repeat (3) next_cycle();
      chk_all_zero("reset");
      rst = 1'b1;
      next_cycle();

      // Correctly predicted taken branch
      drive(1'b0, 1'b1, 1'b1, 32'h100, 32'h08, 1'b1, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      chk("t1_rv", 32'(redirect_valid), 32'd0);
      chk("t1_flush", 32'(flush), 32'd0);
      chk("t1_br", 32'(br_cnt), 32'd1);
      chk("t1_mis", 32'(mis_cnt), 32'd0);
      next_cycle();
      chk("t1_drained", 32'(upd_exp.size()), 32'd0);

      // Mispredicted not-taken, IF stalls redirect for 3 cycles
      drive(1'b0, 1'b1, 1'b0, 32'h200, 32'h24, 1'b1, 1'b1, 32'h24, 1'b1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t2_rv_held", 32'(redirect_valid), 32'd1);
         chk("t2_pc_held", redirect_pc, 32'h24);
         chk("t2_busy", 32'(res_busy), 32'd1);
         chk("t2_flush", 32'(flush), 32'd1);
         next_cycle();
      end
      redirect_ready = 1'b1;
      next_cycle();
      redirect_ready = 1'b0;
      @(negedge clk);
      chk("t2_rv_drop", 32'(redirect_valid), 32'd0);
      chk("t2_idle", 32'(res_busy), 32'd0);
      chk("t2_flush_off", 32'(flush), 32'd0);
      chk("t2_cnt", 32'({br_cnt, mis_cnt}), 32'h21);
      next_cycle();

      // Held branch resolves once, when hold drops
      for (int i = 0; i < 4; i++)
         drive(1'b1, 1'b0, 1'b0, 32'h400, 32'h3c, 1'b0, 1'b0, 32'h0, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 32'h400, 32'h3c, 1'b1, 1'b0, 32'h0, 1'b0);
      next_cycle();
      chk("t3_cnt", 32'({br_cnt, mis_cnt}), 32'h31);
      chk("t3_drained", 32'(upd_exp.size()), 32'd0);

      // Wrong-path branch arriving while a redirect is pending
      drive(1'b0, 1'b0, 1'b1, 32'h300, 32'h50, 1'b1, 1'b1, 32'h300, 1'b1);
      drive(1'b0, 1'b1, 1'b0, 32'h500, 32'h58, 1'b0, 1'b0, 32'h0, 1'b1);
      @(negedge clk);
      chk("t4_busy", 32'(res_busy), 32'd1);
      chk("t4_cnt", 32'({br_cnt, mis_cnt}), 32'h42);
      redirect_ready = 1'b1;
      next_cycle();
      redirect_ready = 1'b0;
      next_cycle();
      chk("t4_cnt_after", 32'({br_cnt, mis_cnt}), 32'h42);
      chk("t4_drained", 32'(upd_exp.size() + redir_exp.size()), 32'd0);

      // Asynchronous reset in the middle of REDIR
      drive(1'b0, 1'b1, 1'b0, 32'h600, 32'h44, 1'b1, 1'b0, 32'h0, 1'b1);
      ex_valid = 1'b1; ex_branch = 1'b1; ex_prdt_br = 1'b1; ex_taken = 1'b0;
      @(negedge clk);
      chk("t5_rv_before", 32'(redirect_valid), 32'd1);
      #2 rst = 1'b0;
      #1 chk_all_zero("t5_async");
      next_cycle();
      chk_all_zero("t5_held");
      idle_in();
      rst = 1'b1;
      @(negedge clk);
      chk("t5_idle", 32'({res_busy, redirect_valid}), 32'd0);
      chk("t5_drained", 32'(upd_exp.size()), 32'd0);
      next_cycle();

      // Saturation: 15 correct branches then a mispredict
      for (int i = 0; i < 15; i++)
         drive(1'b0, 1'b0, 1'b0, 32'h700, 32'h10, 1'b1, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      chk("t6_br_full", 32'(br_cnt), 32'd15);
      next_cycle();
      drive(1'b0, 1'b1, 1'b0, 32'h800, 32'h60, 1'b1, 1'b1, 32'h60, 1'b1);
      // same-cycle ready: a single REDIR cycle
      redirect_ready = 1'b1;
      @(negedge clk);
      chk("t6_rv", 32'(redirect_valid), 32'd1);
      next_cycle();
      redirect_ready = 1'b0;
      @(negedge clk);
      chk("t6_rv_drop", 32'({res_busy, redirect_valid}), 32'd0);
      chk("t6_br_sat", 32'(br_cnt), 32'd15);
      chk("t6_mis", 32'(mis_cnt), 32'd1);
      next_cycle();
      drive(1'b0, 1'b1, 1'b1, 32'h900, 32'h64, 1'b1, 1'b0, 32'h0, 1'b0);
      next_cycle();
      chk("t6_br_sat2", 32'(br_cnt), 32'd15);
      chk("t6_mis2", 32'(mis_cnt), 32'd1);
      chk("final_drained", 32'(upd_exp.size() + redir_exp.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
